// File: rtl/cdr_rx.sv
// Clock/data recovery for the Zigbee receive path: locks a phase counter onto
// transitions of the oversampled demodulated bitstream and strobes one bit per period.
module cdr_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int TOL        = 2,
  parameter int LOCK_EDGES = 4,
  parameter int MAX_MISS   = 2,
  parameter int MAX_RUN    = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic rx_in,
  output logic data_out,
  output logic en_cdr,
  output logic locked,
  output logic lock_lost
);

  localparam int PH_W   = $clog2(OVERSAMPLE);
  localparam int GOOD_W = $clog2(LOCK_EDGES + 1);
  localparam int MISS_W = $clog2(MAX_MISS + 1);
  localparam int RUN_W  = $clog2(MAX_RUN + 1);

  localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
  localparam logic [PH_W-1:0]   PH_MAX    = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]   PH_MID    = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0]   PH_LO     = PH_W'(TOL);
  localparam logic [PH_W-1:0]   PH_HI     = PH_W'(OVERSAMPLE - TOL);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_TGT  = GOOD_W'(LOCK_EDGES);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_TGT  = MISS_W'(MAX_MISS);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_RUN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  logic              r_sync1, r_rx_s, r_rx_d;
  state_t            r_state, w_state_nxt;
  logic [PH_W-1:0]   r_ph, w_ph_nxt;
  logic [GOOD_W-1:0] r_good_cnt, w_good_nxt;
  logic [MISS_W-1:0] r_miss_cnt, w_miss_nxt;
  logic [RUN_W-1:0]  r_run_cnt, w_run_nxt;
  logic              r_data_out, r_en_cdr, r_locked, r_lock_lost;
  logic              w_edge, w_good_edge, w_sample, w_strobe;

  // rx_in is asynchronous: two flops before anything looks at it, a third for edges.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_rx_s  <= 1'b0;
      r_rx_d  <= 1'b0;
    end else begin
      r_sync1 <= rx_in;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  assign w_edge      = r_rx_s ^ r_rx_d;
  assign w_good_edge = w_edge && ((r_ph <= PH_LO) || (r_ph >= PH_HI));
  assign w_sample    = (r_ph == PH_MID) && !w_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ph       <= '0;
      r_good_cnt <= '0;
      r_miss_cnt <= '0;
      r_run_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ph       <= w_ph_nxt;
      r_good_cnt <= w_good_nxt;
      r_miss_cnt <= w_miss_nxt;
      r_run_cnt  <= w_run_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = (r_ph == PH_MAX) ? '0 : r_ph + PH_ONE;
    w_good_nxt  = r_good_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_run_nxt   = r_run_cnt;
    w_strobe    = 1'b0;

    if (w_edge) begin
      w_ph_nxt  = PH_ONE;
      w_run_nxt = '0;
    end else if (w_sample) begin
      w_run_nxt = r_run_cnt + RUN_ONE;
    end

    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_state_nxt = S_ACQUIRE;
          w_good_nxt  = '0;
        end
      end
      S_ACQUIRE: begin
        if (w_good_edge) begin
          w_good_nxt = r_good_cnt + GOOD_ONE;
          if (w_good_nxt == GOOD_TGT) begin
            w_state_nxt = S_LOCKED;
            w_miss_nxt  = '0;
          end
        end else if (w_edge) begin
          w_good_nxt = '0;
        end
      end
      S_LOCKED: begin
        if (w_good_edge) begin
          w_miss_nxt = '0;
        end else if (w_edge) begin
          w_miss_nxt = r_miss_cnt + MISS_ONE;
          if (w_miss_nxt == MISS_TGT) begin
            w_state_nxt = S_ACQUIRE;
            w_good_nxt  = '0;
          end
        end
        w_strobe = w_sample && (r_run_cnt < RUN_MAX);
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Too long without a transition: the phase estimate is stale, start over.
    if (w_sample && (r_run_cnt == RUN_MAX) && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_strobe    = 1'b0;
    end

    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_strobe    = 1'b0;
    end

    if (w_state_nxt == S_IDLE) begin
      w_ph_nxt   = '0;
      w_good_nxt = '0;
      w_miss_nxt = '0;
      w_run_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out  <= 1'b0;
      r_en_cdr    <= 1'b0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      if (!enable) begin
        r_data_out <= 1'b0;
      end else if (w_strobe) begin
        r_data_out <= r_rx_s;
      end
      r_en_cdr    <= w_strobe;
      r_locked    <= (w_state_nxt == S_LOCKED);
      r_lock_lost <= (r_state == S_LOCKED) && (w_state_nxt != S_LOCKED);
    end
  end

  assign data_out  = r_data_out;
  assign en_cdr    = r_en_cdr;
  assign locked    = r_locked;
  assign lock_lost = r_lock_lost;

endmodule
